// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX memory-port arbiter: FSM states, default limits
// and the read data returned when an access is aborted by the watchdog.
package dlx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    FETCH = 3'd2,
    DACK  = 3'd3,
    FACK  = 3'd4
  } arbState_e;

  localparam int TIMEOUT_DEFAULT    = 16;
  localparam int FAIR_LIMIT_DEFAULT = 4;

  localparam logic [31:0] ABORT_RDATA = 32'h0000_0000;

  // True while the memory is being asked for something and the watchdog runs.
  function automatic logic isAccessState(input arbState_e s);
    return (s == DATA) || (s == FETCH);
  endfunction

endpackage

// File: rtl/mem_wdog_timer.sv
// Access watchdog: counts cycles while enabled and flags the cycle in which the
// TIMEOUT-th cycle of an access elapses.
module mem_wdog_timer
  import dlx_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturating count so a stuck enable cannot wrap into a second timeout.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = enable && !clear && (count_q == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage,
// with a fairness limit for fetches and a watchdog that aborts hung accesses.
module mem_port_arbiter
  import dlx_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int FAIR_LIMIT = FAIR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_pipe,
  output logic        stall_if,
  output logic        bus_err,
  input  logic        err_clr
);

  localparam int FW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);

  arbState_e   state_q,     state_d;
  logic [FW-1:0] fairCnt_q, fairCnt_d;
  logic        memReq_q,    memReq_d;
  logic        memWe_q,     memWe_d;
  logic [31:0] memAddr_q,   memAddr_d;
  logic [31:0] memWdata_q,  memWdata_d;
  logic [31:0] dmRdata_q,   dmRdata_d;
  logic [31:0] ifRdata_q,   ifRdata_d;
  logic        dmAck_q,     dmAck_d;
  logic        ifAck_q,     ifAck_d;
  logic        busErr_q,    busErr_d;

  logic        busy;
  logic        dataReq;
  logic        wdogTimeout;

  assign busy    = isAccessState(state_q);
  assign dataReq = dm_read | dm_write;

  mem_wdog_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy),
    .timeout (wdogTimeout)
  );

  // Grant decision, access bookkeeping and completion capture.
  always_comb begin
    state_d    = state_q;
    fairCnt_d  = fairCnt_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    dmRdata_d  = dmRdata_q;
    ifRdata_d  = ifRdata_q;
    busErr_d   = err_clr ? 1'b0 : busErr_q;

    case (state_q)
      IDLE: begin
        if (if_req && (fairCnt_q == FAIR_MAX)) begin
          state_d    = FETCH;
          fairCnt_d  = '0;
          memWe_d    = 1'b0;
          memAddr_d  = if_addr;
          memWdata_d = '0;
        end else if (dataReq) begin
          state_d    = DATA;
          memWe_d    = dm_write;
          memAddr_d  = dm_addr;
          memWdata_d = dm_wdata;
          if (if_req && (fairCnt_q != FAIR_MAX)) begin
            fairCnt_d = fairCnt_q + FW'(1);
          end
        end else if (if_req) begin
          state_d    = FETCH;
          fairCnt_d  = '0;
          memWe_d    = 1'b0;
          memAddr_d  = if_addr;
          memWdata_d = '0;
        end
      end
      DATA: begin
        if (mem_ready) begin
          dmRdata_d = mem_rdata;
          state_d   = DACK;
        end else if (wdogTimeout) begin
          dmRdata_d = ABORT_RDATA;
          busErr_d  = 1'b1;
          state_d   = DACK;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          ifRdata_d = mem_rdata;
          state_d   = FACK;
        end else if (wdogTimeout) begin
          ifRdata_d = ABORT_RDATA;
          busErr_d  = 1'b1;
          state_d   = FACK;
        end
      end
      DACK:    state_d = IDLE;
      FACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    memReq_d = isAccessState(state_d);
    dmAck_d  = (state_d == DACK);
    ifAck_d  = (state_d == FACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fairCnt_q  <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      dmRdata_q  <= '0;
      ifRdata_q  <= '0;
      dmAck_q    <= 1'b0;
      ifAck_q    <= 1'b0;
      busErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fairCnt_q  <= fairCnt_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      dmRdata_q  <= dmRdata_d;
      ifRdata_q  <= ifRdata_d;
      dmAck_q    <= dmAck_d;
      ifAck_q    <= ifAck_d;
      busErr_q   <= busErr_d;
    end
  end

  assign mem_req    = memReq_q;
  assign mem_we     = memWe_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign dm_rdata   = dmRdata_q;
  assign if_rdata   = ifRdata_q;
  assign dm_ack     = dmAck_q;
  assign if_ack     = ifAck_q;
  assign bus_err    = busErr_q;

  // The pipeline stalls combinationally so the ack cycle itself releases it.
  assign stall_pipe = dataReq & ~dmAck_q;
  assign stall_if   = stall_pipe | (if_req & ~ifAck_q);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TIMEOUT, 16, max cycles waiting for mem_ready before abort.
  FAIR_LIMIT, 4, consecutive data grants allowed while a fetch is pending.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  clock.
  reset  in  1  reset, asynchronous, active-high.
  if_req  in  1  instruction fetch request.
  if_addr  in  32  fetch address.
  if_rdata  out  32  fetched word.
  if_ack  out  1  one-cycle fetch completion.
  dm_read  in  1  MEM-stage load (EX/MEM mem_read).
  dm_write  in  1  MEM-stage store (EX/MEM mem_write).
  dm_addr  in  32  data address (EX/MEM ALU output).
  dm_wdata  in  32  store data (EX/MEM B).
  dm_rdata  out  32  load data.
  dm_ack  out  1  one-cycle data completion.
  mem_req  out  1  request to single-port memory.
  mem_we  out  1  write enable.
  mem_addr  out  32  memory address.
  mem_wdata  out  32  memory write data.
  mem_rdata  in  32  memory read data.
  mem_ready  in  1  memory completes the current access.
  stall_pipe  out  1  freeze IF/ID, ID/EX, EX/MEM registers.
  stall_if  out  1  freeze PC.
  bus_err  out  1  sticky timeout flag.
  err_clr  in  1  clears bus_err.

Function
REQ-003 The FSM SHALL have states IDLE, DATA, FETCH, DACK, FACK.
REQ-004 In IDLE, dm_read|dm_write SHALL go to DATA; else if_req SHALL go to FETCH; else stay in IDLE.
REQ-005 When the fairness counter equals FAIR_LIMIT and if_req=1, IDLE SHALL go to FETCH even if a data request is present.
REQ-006 The fairness counter SHALL increment on each DATA grant while if_req=1, clear on any FETCH grant, and saturate at FAIR_LIMIT.
REQ-007 On leaving IDLE, address, write data and we SHALL be registered; we=dm_write, so dm_read&dm_write is treated as a write.
REQ-008 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered and held constant throughout DATA/FETCH; mem_req SHALL be 0 in all other states.
REQ-009 mem_ready=1 in DATA/FETCH SHALL register mem_rdata into dm_rdata/if_rdata and go to DACK/FACK.
REQ-010 dm_ack (DACK) and if_ack (FACK) SHALL each be high for exactly one cycle, after which the FSM returns to IDLE; no request is sampled in DACK/FACK.
REQ-011 Minimum latency: request sampled in cycle 0, mem_req high in cycle 1, mem_ready in cycle 1 -> ack in cycle 2.
REQ-012 The watchdog SHALL count cycles in DATA/FETCH; when TIMEOUT cycles elapse without mem_ready, it SHALL set bus_err, load rdata 32'h0, and go to DACK/FACK.
REQ-013 If mem_ready and the timeout occur in the same cycle, mem_ready SHALL win and bus_err SHALL stay unchanged.
REQ-014 bus_err SHALL clear on err_clr; if err_clr and a new timeout coincide, the set SHALL win.
REQ-015 stall_pipe SHALL equal (dm_read|dm_write)&~dm_ack, combinationally.
REQ-016 stall_if SHALL equal stall_pipe | (if_req&~if_ack), combinationally.
REQ-017 Read data outputs SHALL hold their last value until the next completion.
REQ-018 mem_ready outside DATA/FETCH SHALL be ignored.

Reset
REQ-019 Reset SHALL force IDLE, zero the fairness and watchdog counters, and drive every registered output to 0, including mem_req, mem_we, mem_addr, mem_wdata, dm_rdata, if_rdata, dm_ack, if_ack and bus_err.
REQ-020 Reset mid-access SHALL drop mem_req immediately and issue no ack for the aborted access.

Structure
REQ-021 The state enum, TIMEOUT/FAIR_LIMIT defaults and the abort data value SHALL live in shared package dlx_pkg.
REQ-022 The watchdog SHALL be a sub-module mem_wdog_timer, with inputs clear/enable and a timeout output.

Verification
REQ-023 Load with dm_addr=0x100 and mem_ready in the 3rd wait cycle, mem_rdata=0xCAFEF00D -> dm_rdata=0xCAFEF00D, one dm_ack pulse, stall_pipe high until the ack cycle.
REQ-024 dm_write and if_req together in IDLE -> data is served first (mem_we=1), then the fetch; if_ack follows dm_ack by at least 2 cycles.
REQ-025 dm_read held continuously with if_req=1 and zero-wait memory -> a FETCH grant after exactly 4 data grants.
REQ-026 mem_ready never asserted -> abort after 16 cycles, bus_err=1, dm_rdata=0; err_clr pulse -> bus_err=0.
REQ-027 Assert reset during FETCH -> mem_req=0 asynchronously, no if_ack, FSM in IDLE after reset.
REQ-028 mem_ready on the 16th wait cycle -> normal completion, bus_err stays 0.
